// File: rtl/lcd_st_pkg.sv
// Shared definitions for the streaming packet FIFO: word packing layout and a
// constant-function clog2 used to size address buses.
package lcd_st_pkg;

  localparam int unsigned EOP_OFS     = 0;
  localparam int unsigned SOP_OFS     = 1;
  localparam int unsigned DATA_OFS    = 2;
  localparam int unsigned WORD_CTRL_W = 2;

  function automatic int unsigned lcd_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/lcd_st_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// A read of an address being written in the same cycle returns the old contents.
module lcd_st_fifo_ram
  import lcd_st_pkg::*;
#(
  parameter  int unsigned WIDTH = 71,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = lcd_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lcd_st_pkt_fifo.sv
// Streaming FIFO with sop/eop framing, fill/almost flags, a complete-packet
// counter and an optional store-and-forward (packet) gating mode.
module lcd_st_pkt_fifo
  import lcd_st_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 69,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned ADDR_WIDTH      = 4,
  parameter bit          PACKET_MODE     = 1'b0,
  parameter int unsigned ALMOST_FULL_TH  = DEPTH - 2,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   pkt_count
);

  localparam int unsigned WORD_W = DATA_WIDTH + WORD_CTRL_W;
  localparam int unsigned CW     = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, wr_addr_nxt, rd_addr_nxt;
  logic                  full, empty, full_nxt, empty_nxt;
  logic [CW-1:0]         fill_nxt, pkt_nxt, avail, pkts_left;
  logic                  out_valid_nxt, wr_acc, rd_acc;
  logic [WORD_W-1:0]     ram_wdata, ram_rdata;

  assign in_ready = !full;
  assign wr_acc   = in_valid && in_ready && !flush;
  assign rd_acc   = out_valid && out_ready && !flush;

  assign ram_wdata = {in_data, in_sop, in_eop};

  // Read port always looks at the word that will be head after this edge.
  lcd_st_fifo_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_addr),
    .wr_data (ram_wdata),
    .rd_addr (rd_addr_nxt),
    .rd_data (ram_rdata)
  );

  assign out_data = ram_rdata[DATA_OFS +: DATA_WIDTH];
  assign out_sop  = out_valid && ram_rdata[SOP_OFS];
  assign out_eop  = out_valid && ram_rdata[EOP_OFS];

  always_comb begin
    wr_addr_nxt   = wr_addr;
    rd_addr_nxt   = rd_addr;
    full_nxt      = full;
    empty_nxt     = empty;
    pkt_nxt       = pkt_count;
    avail         = '0;
    pkts_left     = '0;
    out_valid_nxt = 1'b0;

    if (wr_acc) wr_addr_nxt = wr_addr + ADDR_WIDTH'(1);
    if (rd_acc) rd_addr_nxt = rd_addr + ADDR_WIDTH'(1);

    if (wr_acc && !rd_acc) begin
      full_nxt  = (wr_addr_nxt == rd_addr);
      empty_nxt = 1'b0;
    end else if (rd_acc && !wr_acc) begin
      empty_nxt = (rd_addr_nxt == wr_addr);
      full_nxt  = 1'b0;
    end

    if ((wr_acc && in_eop) && !(rd_acc && out_eop))
      pkt_nxt = pkt_count + CW'(1);
    else if (!(wr_acc && in_eop) && (rd_acc && out_eop))
      pkt_nxt = pkt_count - CW'(1);

    // Only words already in RAM before this edge can be presented after it.
    avail         = fill_level - CW'(rd_acc);
    pkts_left     = pkt_count - CW'(rd_acc && out_eop);
    out_valid_nxt = (avail != '0) &&
                    (!PACKET_MODE || (pkts_left != '0) || full_nxt);

    if (flush) begin
      wr_addr_nxt   = '0;
      rd_addr_nxt   = '0;
      full_nxt      = 1'b0;
      empty_nxt     = 1'b1;
      pkt_nxt       = '0;
      out_valid_nxt = 1'b0;
    end

    fill_nxt = full_nxt ? CW'(DEPTH) : {1'b0, wr_addr_nxt - rd_addr_nxt};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr      <= '0;
      rd_addr      <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      out_valid    <= 1'b0;
      fill_level   <= '0;
      pkt_count    <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_addr      <= wr_addr_nxt;
      rd_addr      <= rd_addr_nxt;
      full         <= full_nxt;
      empty        <= empty_nxt;
      out_valid    <= out_valid_nxt;
      fill_level   <= fill_nxt;
      pkt_count    <= pkt_nxt;
      almost_full  <= (fill_nxt >= CW'(ALMOST_FULL_TH));
      almost_empty <= (fill_nxt <= CW'(ALMOST_EMPTY_TH));
    end
  end

endmodule

// File: doc/lcd_st_pkt_fifo.md
LCD_ST_PKT_FIFO -- requirements
Module: lcd_st_pkt_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 69: payload bits per word.
REQ-002 Parameter DEPTH, default 16: number of storage words; power of two, 4..1024.
REQ-003 Parameter ADDR_WIDTH, default 4: log2(DEPTH).
REQ-004 Parameter PACKET_MODE, default 0: when 1, out_valid is gated until a complete packet is stored.
REQ-005 Parameter ALMOST_FULL_TH, default DEPTH-2; parameter ALMOST_EMPTY_TH, default 2.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 flush  in  1  synchronous clear of all contents.
REQ-009 in_valid in 1 / in_ready out 1 / in_data in DATA_WIDTH / in_sop in 1 / in_eop in 1: write side.
REQ-010 out_ready in 1 / out_valid out 1 / out_data out DATA_WIDTH / out_sop out 1 / out_eop out 1: read side.
REQ-011 fill_level  out  ADDR_WIDTH+1  words stored, 0..DEPTH.
REQ-012 almost_full out 1, almost_empty out 1, pkt_count out ADDR_WIDTH+1 (complete packets stored).

Function
REQ-013 Write accept = in_valid & in_ready; read accept = out_valid & out_ready; sop/eop are stored with the word.
REQ-014 in_ready = !full, combinational from registered state; it never depends on in_valid.
REQ-015 Memory is DEPTH x (DATA_WIDTH+2); read address = next_rd_addr on a read accept, else rd_addr; out_data/out_sop/out_eop are registered.
REQ-016 Latency: a word accepted into an empty FIFO at edge N appears with out_valid=1 after edge N+1.
REQ-017 out_valid is registered; it deasserts on the edge that reads the last stored word.
REQ-018 Pointers wrap modulo DEPTH; full/empty come from a separate registered flag, never from pointer equality alone.
REQ-019 Simultaneous write and read accept: fill_level, full and empty are unchanged; both pointers advance.
REQ-020 fill_level = wr_addr - rd_addr (ADDR_WIDTH bits, zero-extended); when full, fill_level = DEPTH.
REQ-021 almost_full = (fill_level >= ALMOST_FULL_TH); almost_empty = (fill_level <= ALMOST_EMPTY_TH); both registered, consistent with fill_level in the same cycle.
REQ-022 pkt_count increments on a write accept with in_eop=1 and decrements on a read accept with out_eop=1; both together leave it unchanged.
REQ-023 PACKET_MODE=1: out_valid requires pkt_count>0 OR full; the full override prevents deadlock on packets longer than DEPTH.
REQ-024 PACKET_MODE=0: pkt_count is still maintained; out_valid depends only on non-empty.
REQ-025 flush=1 at an edge: pointers, flags, fill_level and pkt_count are set to reset values; any accept in that cycle is discarded; in_ready=1 in the next cycle.
REQ-026 No sop/eop framing check; malformed framing is stored as given.

Reset
REQ-027 On reset_n=0: wr_addr=rd_addr=0, empty=1, full=0, out_valid=0, fill_level=0, pkt_count=0, almost_full=0, almost_empty=1, out_sop=out_eop=0.
REQ-028 out_data is undefined after reset until the first valid word; the memory array is not reset.
REQ-029 Reset asserted mid-transfer discards all contents; in_ready=1 from the first edge after release.

Structure
REQ-030 Shared package lcd_st_pkg: the sop/eop word-packing offsets and a clog2 constant function.
REQ-031 One sub-module, lcd_st_fifo_ram: a simple dual-port RAM, one write port and one registered read port, with no reset.

Verification
REQ-032 DEPTH=8, PACKET_MODE=0: write 8 words without reading -> in_ready=0 after the 8th accept, fill_level=8, almost_full=1; read 8 -> data 0..7 in order, out_valid=0, fill_level=0.
REQ-033 Continuous in_valid=out_ready=1 for 100 cycles -> fill_level holds constant; data strictly sequential; no bubble after the initial latency.
REQ-034 PACKET_MODE=1: write 3 words, EOP on word 3 -> out_valid=0 until 1 cycle after the EOP accept; pkt_count=1, then 0 after the 3rd read.
REQ-035 PACKET_MODE=1, 10-word packet into DEPTH=8 -> out_valid asserts when full; all 10 words delivered; no deadlock.
REQ-036 Assert flush with 5 words stored and simultaneous in_valid -> next cycle fill_level=0, out_valid=0, pkt_count=0; no flushed word ever emerges.
REQ-037 Random valid/ready (seed 23, 20*DEPTH cycles), with reset_n pulsed mid-run -> scoreboard matches; after reset: out_valid=0, fill_level=0.
